mult_div_unit: RTL

//  Multicycle signed multiply/divide responder for the MIPS datapath.
//  The control unit pulses mult_start/div_start. This block runs a radix-2 Booth

---
 rtl/mult_div_unit_pkg.sv | 33 +++
 rtl/mult_div_unit_if.sv | 27 ++
 rtl/mult_div_unit_div_restoring_step.sv | 28 ++
 rtl/mult_div_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared types for the multiply/divide unit: state encoding, op select, width.
// Ports: none (package).
package mult_div_unit_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MULT,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_MULT,
    OP_DIV,
    OP_DIVZ
  } op_t;

  // Multiply has priority when both starts are raised together.
  function automatic op_t pick_op(
    input logic ms,
    input logic ds,
    input logic bz
  );
    if (ms) return OP_MULT;
    if (ds) return bz ? OP_DIVZ : OP_DIV;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Control-unit <-> mult/div handshake: starts, operands, HI/LO, status.
// master = control unit (drives starts/operands), slave = mult_div_unit.
interface mult_div_unit_if
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             mult_start;
  logic             div_start;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic [WIDTH-1:0] HI_out;
  logic [WIDTH-1:0] LO_out;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output mult_start, div_start, A_in, B_in,
    input  HI_out, LO_out, busy, done, div_zero
  );

  modport slave (
    input  mult_start, div_start, A_in, B_in,
    output HI_out, LO_out, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit_div_restoring_step.sv
// One restoring-division iteration on unsigned magnitudes.
// in: r (partial remainder), q (dividend/quotient), d (|divisor|); out: r_next, q_next.
module div_restoring_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] trial;

  // One extra bit so the trial subtraction sign is exact
  // even when |divisor| is 2^(WIDTH-1).
  assign r_sh  = {r, q[WIDTH-1]};
  assign trial = r_sh - {1'b0, d};

  always_comb begin
    r_next = r_sh[WIDTH-1:0];
    q_next = {q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      r_next = trial[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) for HI/LO.
// Ports: clk, reset (async, active-high), bus (slave side of mult_div_unit_if).
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);
  state_t           state;
  logic [4:0]       cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q_reg;
  logic             q1;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] d;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             dz;

  op_t              op;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   b_sum;
  logic [WIDTH:0]   acc_nx;
  logic [WIDTH-1:0] qm_nx;
  logic [WIDTH-1:0] r_nx;
  logic [WIDTH-1:0] qd_nx;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             last;

  assign op = pick_op(bus.mult_start, bus.div_start,
                      bus.B_in == '0);

  assign a_abs = bus.A_in[WIDTH-1] ? -bus.A_in : bus.A_in;
  assign b_abs = bus.B_in[WIDTH-1] ? -bus.B_in : bus.B_in;
  assign last  = (cnt == 5'(WIDTH - 1));

  // Accumulator carries one guard bit so that subtracting the
  // most negative multiplicand cannot overflow.
  assign m_ext = {m[WIDTH-1], m};

  always_comb begin
    unique case ({q_reg[0], q1})
      2'b01:   b_sum = acc + m_ext;
      2'b10:   b_sum = acc - m_ext;
      default: b_sum = acc;
    endcase
  end

  assign acc_nx = {b_sum[WIDTH], b_sum[WIDTH:1]};
  assign qm_nx  = {b_sum[0], q_reg[WIDTH-1:1]};

  div_restoring_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .r      (r),
    .q      (q_reg),
    .d      (d),
    .r_next (r_nx),
    .q_next (qd_nx)
  );

  assign q_fix = (a_neg ^ b_neg) ? -q_reg : q_reg;
  assign r_fix = a_neg ? -r : r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
      q_reg <= '0;
      q1    <= 1'b0;
      m     <= '0;
      r     <= '0;
      d     <= '0;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          unique case (op)
            OP_MULT: begin
              acc   <= '0;
              q_reg <= bus.A_in;
              q1    <= 1'b0;
              m     <= bus.B_in;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= ST_MULT;
            end
            OP_DIV: begin
              r     <= '0;
              q_reg <= a_abs;
              d     <= b_abs;
              a_neg <= bus.A_in[WIDTH-1];
              b_neg <= bus.B_in[WIDTH-1];
              cnt   <= '0;
              busy  <= 1'b1;
              state <= ST_DIV;
            end
            OP_DIVZ: begin
              done  <= 1'b1;
              dz    <= 1'b1;
              state <= ST_DONE;
            end
            default: ;
          endcase
        end
        ST_MULT: begin
          acc   <= acc_nx;
          q_reg <= qm_nx;
          q1    <= q_reg[0];
          cnt   <= cnt + 5'd1;
          if (last) begin
            hi    <= acc_nx[WIDTH-1:0];
            lo    <= qm_nx;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DIV: begin
          r     <= r_nx;
          q_reg <= qd_nx;
          cnt   <= cnt + 5'd1;
          if (last) state <= ST_FIX;
        end
        ST_FIX: begin
          lo    <= q_fix;
          hi    <= r_fix;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          dz    <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.HI_out   = hi;
  assign bus.LO_out   = lo;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.div_zero = dz;
endmodule
